// File: rtl/sprite_reg_write_master.sv
// Purpose : Avalon-MM write initiator that replays committed batches of sprite/score
//           register updates into the VGA register slave, one batch per vertical blank.
// Latency : vsync first sampled low at edge N while armed -> first write on the bus in
//           cycle N+1; K entries with no stalls occupy cycles N+1..N+K, DONE in N+K+1.
// Backpressure: cmd_ready drops while the FIFO is full, during a flush and during reset;
//           avm_waitrequest freezes the bus (address, data and strobes held stable).
//
// Ports
//   clk, reset                      system clock; asynchronous active-high reset
//   cmd_valid/cmd_ready             upstream push handshake
//   cmd_addr/cmd_data/cmd_last      entry payload; cmd_last commits the batch
//   vga_vs                          active-low vsync from the VGA timing generator
//   avm_chipselect/avm_write        Avalon-MM strobes (asserted together in BURST)
//   avm_address/avm_writedata       Avalon-MM write address / data (0 when idle)
//   avm_waitrequest                 slave stall
//   busy                            FSM not idle
//   frame_count                     batches fully written, wraps at 16 bits
//   overflow_err                    sticky: an uncommitted batch filled the FIFO

module sprite_reg_write_master #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_last,
   input  logic              vga_vs,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [ADDR_W-1:0] avm_address,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic [15:0]       frame_count,
   output logic              overflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 1 + ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   pending_q, pending_d;   // committed batches still in the FIFO
   logic               vs_q;
   logic [15:0]        frame_count_q, frame_count_d;
   logic               overflow_err_q, overflow_err_d;
   logic               flush_q, flush_d;

   // Entry storage: {last, addr, data}. Not reset; validity is tracked by the pointers.
   logic [ENT_W-1:0]   mem_q [DEPTH];

   // ------------------------------------------------------------------
   // FIFO head decode and handshake terms
   // ------------------------------------------------------------------
   logic [ENT_W-1:0]   head;
   logic               head_last;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;

   logic full;
   logic push;
   logic pop;
   logic push_last;
   logic retire_last;
   logic in_burst;
   logic vblank_start;
   logic ovf_trig;

   assign head      = mem_q[rd_ptr_q];
   assign head_last = head[ENT_W-1];
   assign head_addr = head[DATA_W +: ADDR_W];
   assign head_data = head[DATA_W-1:0];

   assign full      = (count_q == CNT_W'(DEPTH));
   assign in_burst  = (state_q == S_BURST);

   // A full FIFO with nothing committed can never drain: the open batch is lost.
   // flush_q masks the trigger so the flush lasts exactly one cycle.
   assign ovf_trig  = full && (pending_q == '0) && !flush_q;

   // Gated with reset so the handshake is closed for the whole reset window.
   assign cmd_ready = !reset && !full && !flush_q;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = in_burst && !avm_waitrequest;
   assign push_last = push && cmd_last;
   assign retire_last = pop && head_last;

   // Falling edge of the active-low vsync marks vertical-blank onset.
   assign vblank_start = vs_q && !vga_vs;

   // ------------------------------------------------------------------
   // FIFO, pending and status next-state
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      pending_d      = pending_q + CNT_W'(push_last) - CNT_W'(retire_last);
      frame_count_d  = frame_count_q;
      overflow_err_d = overflow_err_q | ovf_trig;
      flush_d        = ovf_trig;

      if (flush_q) begin
         // No push (cmd_ready low) and no pop (nothing committed) can coincide.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      if (state_q == S_DONE) begin
         frame_count_d = frame_count_q + 16'd1;
      end
   end

   // ------------------------------------------------------------------
   // Control FSM next-state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (pending_q != '0) begin
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (vblank_start) begin
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (retire_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // pending already reflects the batch just retired, so a further
            // committed batch waits for the next vblank.
            if (pending_q != '0) begin
               state_d = S_ARMED;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         pending_q      <= '0;
         vs_q           <= 1'b1;
         frame_count_q  <= '0;
         overflow_err_q <= 1'b0;
         flush_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         pending_q      <= pending_d;
         vs_q           <= vga_vs;
         frame_count_q  <= frame_count_d;
         overflow_err_q <= overflow_err_d;
         flush_q        <= flush_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_last, cmd_addr, cmd_data};
      end
   end

   // ------------------------------------------------------------------
   // Outputs: bus is driven only in BURST, so reset drops it asynchronously
   // ------------------------------------------------------------------
   assign avm_chipselect = in_burst;
   assign avm_write      = in_burst;
   assign avm_address    = in_burst ? head_addr : '0;
   assign avm_writedata  = in_burst ? head_data : '0;
   assign busy           = (state_q != S_IDLE);
   assign frame_count    = frame_count_q;
   assign overflow_err   = overflow_err_q;

endmodule

// File: tb/tb_sprite_reg_write_master.sv
module tb_sprite_reg_write_master;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_last;
   logic              vga_vs;
   logic              avm_chipselect;
   logic              avm_write;
   logic [ADDR_W-1:0] avm_address;
   logic [DATA_W-1:0] avm_writedata;
   logic              avm_waitrequest;
   logic              busy;
   logic [15:0]       frame_count;
   logic              overflow_err;

   // Slave stall: forced by a scenario, or random when enabled.
   logic wr_force    = 1'b0;
   logic wr_rand_en  = 1'b0;
   logic wr_rand_bit = 1'b0;
   assign avm_waitrequest = wr_force | (wr_rand_en & wr_rand_bit);

   int n_checks  = 0;
   int n_pass    = 0;
   int cs_cycles = 0;

   // Writes accepted by the slave, in bus order.
   logic [ADDR_W-1:0] obs_addr [$];
   logic [DATA_W-1:0] obs_data [$];

   // Reference model: entries queued but not yet written, and frames written.
   logic [ADDR_W-1:0] m_addr [$];
   logic [DATA_W-1:0] m_data [$];
   logic              m_last [$];
   int                m_frames = 0;

   sprite_reg_write_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_addr       (cmd_addr),
      .cmd_data       (cmd_data),
      .cmd_last       (cmd_last),
      .vga_vs         (vga_vs),
      .avm_chipselect (avm_chipselect),
      .avm_write      (avm_write),
      .avm_address    (avm_address),
      .avm_writedata  (avm_writedata),
      .avm_waitrequest(avm_waitrequest),
      .busy           (busy),
      .frame_count    (frame_count),
      .overflow_err   (overflow_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      wr_rand_bit = ($urandom_range(0, 3) == 0);
   end

   always @(negedge clk) begin
      if (avm_chipselect) cs_cycles++;
      if (avm_chipselect && avm_write && !avm_waitrequest) begin
         obs_addr.push_back(avm_address);
         obs_data.push_back(avm_writedata);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_addr.delete();
      m_data.delete();
      m_last.delete();
      m_frames = 0;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_data   = '0;
      cmd_last   = 1'b0;
      vga_vs     = 1'b1;
      wr_force   = 1'b0;
      wr_rand_en = 1'b0;
      step();
      step();
      reset = 1'b0;
      model_clear();
      step();
   endtask

   task automatic push_entry(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic l);
      int t;
      t = 0;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_last  = l;
      while (cmd_ready !== 1'b1 && t < 64) begin
         step();
         t++;
      end
      if (t >= 64) begin
         n_checks++;
         $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
      end else begin
         step();
         m_addr.push_back(a);
         m_data.push_back(d);
         m_last.push_back(l);
      end
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
   endtask

   // One vblank: the model predicts the oldest committed batch (if any) is written.
   task automatic vblank_expect(input string tag);
      logic [ADDR_W-1:0] ea [$];
      logic [DATA_W-1:0] ed [$];
      int  base, t;
      bit  have_batch;
      logic l;
      base = obs_addr.size();
      have_batch = 1'b0;
      foreach (m_last[i]) if (m_last[i]) have_batch = 1'b1;
      if (have_batch) begin
         do begin
            ea.push_back(m_addr.pop_front());
            ed.push_back(m_data.pop_front());
            l = m_last.pop_front();
         end while (!l);
         m_frames++;
      end
      step();
      step();
      vga_vs = 1'b0;
      step();
      step();
      vga_vs = 1'b1;
      t = 0;
      while (have_batch && frame_count !== 16'(m_frames) && t < 400) begin
         step();
         t++;
      end
      repeat (12) step();
      n_checks++;
      if (frame_count !== 16'(m_frames))
         $display("FAIL %s frame_count: got %0d, required %0d", tag, frame_count, m_frames);
      else n_pass++;
      n_checks++;
      if (obs_addr.size() - base != ea.size())
         $display("FAIL %s write_count: got %0d, required %0d", tag, obs_addr.size() - base, ea.size());
      else n_pass++;
      for (int i = 0; i < ea.size(); i++) begin
         if (base + i < obs_addr.size()) begin
            n_checks++;
            if ({obs_addr[base+i], obs_data[base+i]} !== {ea[i], ed[i]})
               $display("FAIL %s write[%0d]: got addr %0d data %h, required addr %0d data %h",
                        tag, i, obs_addr[base+i], obs_data[base+i], ea[i], ed[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      push_entry(9'd3, 32'h1234, 1'b1);
      @(negedge clk);
      reset     = 1'b1;
      cmd_valid = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); else n_pass++;
      n_checks++; if (avm_chipselect !== 1'b0) $display("FAIL reset_cs: got %b, required 0", avm_chipselect); else n_pass++;
      n_checks++; if (avm_write !== 1'b0) $display("FAIL reset_write: got %b, required 0", avm_write); else n_pass++;
      n_checks++; if (avm_address !== '0) $display("FAIL reset_addr: got %0d, required 0", avm_address); else n_pass++;
      n_checks++; if (avm_writedata !== '0) $display("FAIL reset_data: got %h, required 0", avm_writedata); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
      n_checks++; if (frame_count !== 16'd0) $display("FAIL reset_frame_count: got %0d, required 0", frame_count); else n_pass++;
      n_checks++; if (overflow_err !== 1'b0) $display("FAIL reset_overflow: got %b, required 0", overflow_err); else n_pass++;
      step();
      step();
      n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_held_ready: got %b, required 0", cmd_ready); else n_pass++;
      cmd_valid = 1'b0;
      reset = 1'b0;
      model_clear();
      step();
      step();
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_ready: got %b, required 1", cmd_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b, required 0 (FIFO emptied)", busy); else n_pass++;
   endtask

   task automatic test_basic_batch();
      logic [ADDR_W-1:0] ea [3];
      logic [DATA_W-1:0] ed [3];
      ea[0] = 9'd0;   ed[0] = 32'd100;
      ea[1] = 9'd1;   ed[1] = 32'd100;
      ea[2] = 9'd10;  ed[2] = 32'd7;
      do_reset();
      for (int i = 0; i < 3; i++) push_entry(ea[i], ed[i], i == 2);
      step();
      step();
      n_checks++; if (busy !== 1'b1) $display("FAIL basic_armed_busy: got %b, required 1", busy); else n_pass++;
      vga_vs = 1'b0;
      @(posedge clk);                       // edge N: vsync first sampled low
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);                    // cycle N+1+i
         n_checks++;
         if ({avm_chipselect, avm_write, avm_address, avm_writedata} !== {1'b1, 1'b1, ea[i], ed[i]})
            $display("FAIL basic_write[%0d]: got cs %b wr %b addr %0d data %0d, required 1 1 %0d %0d",
                     i, avm_chipselect, avm_write, avm_address, avm_writedata, ea[i], ed[i]);
         else n_pass++;
         @(posedge clk);
      end
      @(negedge clk);                       // cycle N+4: DONE
      n_checks++; if ({avm_chipselect, busy} !== 2'b01) $display("FAIL basic_done: got cs %b busy %b, required 0 1", avm_chipselect, busy); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_drop: got %b, required 0", busy); else n_pass++;
      n_checks++; if (frame_count !== 16'd1) $display("FAIL basic_frame_count: got %0d, required 1", frame_count); else n_pass++;
      step();
      vga_vs = 1'b1;
      step();
   endtask

   task automatic test_partial_batch();
      int base_cs;
      do_reset();
      base_cs = cs_cycles;
      push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, 1'b0);
      push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, 1'b0);
      repeat (3) begin
         vga_vs = 1'b0;
         step();
         step();
         vga_vs = 1'b1;
         step();
         step();
      end
      repeat (4) step();
      n_checks++; if (cs_cycles != base_cs) $display("FAIL partial_no_cs: got %0d cs cycles, required 0", cs_cycles - base_cs); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b, required 0", busy); else n_pass++;
   endtask

   task automatic test_two_batches();
      do_reset();
      for (int i = 0; i < 2; i++) push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, i == 1);
      for (int i = 0; i < 3; i++) push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, i == 2);
      vblank_expect("batch_a");
      n_checks++; if (busy !== 1'b1) $display("FAIL batch_b_waiting: busy got %b, required 1", busy); else n_pass++;
      vblank_expect("batch_b");
      n_checks++; if (busy !== 1'b0) $display("FAIL two_batches_idle: busy got %b, required 0", busy); else n_pass++;
   endtask

   task automatic test_wait_stall();
      logic [ADDR_W-1:0] a [3];
      logic [DATA_W-1:0] d [3];
      int held, base;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a[i] = ADDR_W'($urandom_range(0, 12));
         d[i] = $urandom;
         push_entry(a[i], d[i], i == 2);
      end
      base = obs_addr.size();
      step();
      step();
      vga_vs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({avm_chipselect, avm_address, avm_writedata} !== {1'b1, a[0], d[0]})
         $display("FAIL stall_first: got cs %b addr %0d data %h, required 1 %0d %h", avm_chipselect, avm_address, avm_writedata, a[0], d[0]);
      else n_pass++;
      @(posedge clk);
      #1;
      wr_force = 1'b1;
      held = 0;
      repeat (3) begin
         @(negedge clk);
         if (avm_chipselect && avm_write && avm_address === a[1] && avm_writedata === d[1]) held++;
         @(posedge clk);
         #1;
      end
      wr_force = 1'b0;
      @(negedge clk);
      if (avm_chipselect && avm_write && avm_address === a[1] && avm_writedata === d[1]) held++;
      n_checks++; if (held != 4) $display("FAIL stall_hold: second write held %0d cycles, required 4", held); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({avm_chipselect, avm_address, avm_writedata} !== {1'b1, a[2], d[2]})
         $display("FAIL stall_third: got cs %b addr %0d data %h, required 1 %0d %h", avm_chipselect, avm_address, avm_writedata, a[2], d[2]);
      else n_pass++;
      step();
      vga_vs = 1'b1;
      repeat (3) step();
      n_checks++; if (frame_count !== 16'd1) $display("FAIL stall_frame_count: got %0d, required 1", frame_count); else n_pass++;
      n_checks++; if (obs_addr.size() - base != 3) $display("FAIL stall_write_count: got %0d, required 3", obs_addr.size() - base); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         if (base + i < obs_addr.size()) begin
            n_checks++;
            if ({obs_addr[base+i], obs_data[base+i]} !== {a[i], d[i]})
               $display("FAIL stall_order[%0d]: got addr %0d data %h, required %0d %h", i, obs_addr[base+i], obs_data[base+i], a[i], d[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_overflow();
      int base_cs;
      do_reset();
      base_cs = cs_cycles;
      for (int i = 0; i < DEPTH; i++) push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, 1'b0);
      // Now in the cycle after the 16th push: FIFO full, nothing committed.
      n_checks++; if ({cmd_ready, overflow_err} !== 2'b00) $display("FAIL ovf_full: got ready %b err %b, required 0 0", cmd_ready, overflow_err); else n_pass++;
      step();
      n_checks++; if ({cmd_ready, overflow_err} !== 2'b01) $display("FAIL ovf_flush_cycle: got ready %b err %b, required 0 1", cmd_ready, overflow_err); else n_pass++;
      step();
      n_checks++; if ({cmd_ready, overflow_err} !== 2'b11) $display("FAIL ovf_recovered: got ready %b err %b, required 1 1", cmd_ready, overflow_err); else n_pass++;
      model_clear();
      n_checks++; if (cs_cycles != base_cs) $display("FAIL ovf_no_writes: got %0d cs cycles, required 0", cs_cycles - base_cs); else n_pass++;
      // Only this new entry may be written if the flush really emptied the FIFO.
      push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, 1'b1);
      vblank_expect("ovf_after_flush");
      n_checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow_err); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int i = 0; i < 4; i++) push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, i == 3);
      step();
      step();
      vga_vs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);                       // second write on the bus
      n_checks++; if (avm_chipselect !== 1'b1) $display("FAIL midburst_active: cs got %b, required 1", avm_chipselect); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if ({avm_chipselect, avm_write} !== 2'b00) $display("FAIL midburst_strobes: got cs %b wr %b, required 0 0", avm_chipselect, avm_write); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL midburst_busy: got %b, required 0", busy); else n_pass++;
      n_checks++; if (frame_count !== 16'd0) $display("FAIL midburst_frame_count: got %0d, required 0", frame_count); else n_pass++;
      step();
      vga_vs = 1'b1;
      step();
      reset = 1'b0;
      model_clear();
      step();
      vblank_expect("after_reset_discard");
   endtask

   task automatic test_random_batches();
      int nb, sz, nv;
      do_reset();
      wr_rand_en = 1'b1;
      for (int r = 0; r < 8; r++) begin
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            sz = $urandom_range(1, 4);
            if (m_addr.size() + sz <= DEPTH - 2)
               for (int k = 0; k < sz; k++)
                  push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, k == sz - 1);
         end
         if ($urandom_range(0, 1) == 1 && m_addr.size() < DEPTH - 2)
            push_entry(ADDR_W'($urandom_range(0, 12)), $urandom, 1'b0);
         nv = 1;
         foreach (m_last[i]) if (m_last[i]) nv++;
         for (int v = 0; v < nv; v++) vblank_expect($sformatf("rand_r%0d_v%0d", r, v));
      end
      wr_rand_en = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      cmd_last  = 1'b0;
      vga_vs    = 1'b1;
      test_reset();
      test_basic_batch();
      test_partial_batch();
      test_two_batches();
      test_wait_stall();
      test_overflow();
      test_reset_mid_burst();
      test_random_batches();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
